// File: rtl/mips32_loader_pkg.sv
// Shared definitions for the MIPS32 program loader: loader state encoding,
// the machine word width, and the HALT opcode that the core also uses.
// Optional build macro honoured by the loader: MIPS32_LOADER_CHECKSUM_EN.
package mips32_loader_pkg;

    localparam int WORD_W = 32;

    // Primary opcode of the HALT instruction, matching the core's decoder.
    localparam logic [5:0] HALT_OPCODE = 6'h3f;

    typedef enum logic [2:0] {
        IDLE,
        HDR_CNT,
        HDR_ADDR,
        DATA,
        CHK,
        START,
        RUN,
        ERR
    } state_t;

endpackage

// File: rtl/mips32_byte_packer.sv
// Packs a big-endian byte stream into 32-bit words. The first byte of a word
// lands in bits [31:24]. o_word_valid pulses combinationally with the fourth
// accepted byte, and o_word is the completed word during that same cycle.
module mips32_byte_packer
    import mips32_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [7:0]        i_byte,
    output logic              o_word_valid,
    output logic [WORD_W-1:0] o_word
);

    logic [1:0]  r_idx;
    logic [23:0] r_shift;

    // Track the byte position within the word and shift earlier bytes up.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_valid) begin
            r_idx   <= r_idx + 2'd1;
            r_shift <= {r_shift[15:0], i_byte};
        end
    end

    assign o_word_valid = i_valid && (r_idx == 2'd3);
    assign o_word       = {r_shift, i_byte};

endmodule

// File: rtl/mips32_prog_loader.sv
// Boot-time program loader for the MIPS32 pipeline. It receives a header
// (word count N, load address A) and N program words over a byte stream. It
// writes the words to core memory, then releases the core at PC=A.
// Optional build macro: MIPS32_LOADER_CHECKSUM_EN adds a trailing checksum
// word equal to N ^ A ^ (all data words). The core is released only if the
// checksum matches.
module mips32_prog_loader
    import mips32_loader_pkg::*;
#(
    parameter int AW        = 10,
    parameter int MAX_WORDS = 1024
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          core_halt,
    output logic [31:0]   core_pc_init,
    output logic          core_start,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [32:0] DEPTH = 33'd1 << AW;
    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

    state_t r_state;
    state_t w_state_next;

    logic              w_xfer;
    logic              w_word_valid;
    logic [WORD_W-1:0] w_word;
    logic              w_addr_ovf;
    logic              w_data_done;

    logic [31:0]   r_n;
    logic [31:0]   r_word_cnt;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [31:0]   r_pc_init;
`ifdef MIPS32_LOADER_CHECKSUM_EN
    logic [31:0]   r_csum;
`endif

    // Bytes are accepted only while a word is expected. In DATA, acceptance
    // stops once the last word is complete, while its write is still pending.
    assign in_ready = (r_state == HDR_CNT) || (r_state == HDR_ADDR) ||
                      (r_state == CHK) ||
                      ((r_state == DATA) && (r_word_cnt != r_n));
    assign w_xfer   = in_valid && in_ready;

    mips32_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (w_xfer),
        .i_byte       (in_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // The load window must fit in memory. The 33-bit sum keeps the carry.
    assign w_addr_ovf  = ({1'b0, w_word} + {1'b0, r_n}) > DEPTH;
    // The final data write is on the bus this cycle.
    assign w_data_done = (r_state == DATA) && r_mem_we && (r_word_cnt == r_n);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state decode and the state-decoded control outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_next = r_state;
        core_halt    = 1'b1;
        core_start   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            IDLE: w_state_next = HDR_CNT;
            HDR_CNT: begin
                busy = 1'b1;
                if (w_word_valid) begin
                    if (w_word == 32'd0)    w_state_next = START;
                    else if (w_word > MAX_N) w_state_next = ERR;
                    else                    w_state_next = HDR_ADDR;
                end
            end
            HDR_ADDR: begin
                busy = 1'b1;
                if (w_word_valid) w_state_next = w_addr_ovf ? ERR : DATA;
            end
            DATA: begin
                busy = 1'b1;
`ifdef MIPS32_LOADER_CHECKSUM_EN
                if (w_data_done) w_state_next = CHK;
`else
                if (w_data_done) w_state_next = START;
`endif
            end
`ifdef MIPS32_LOADER_CHECKSUM_EN
            CHK: begin
                busy = 1'b1;
                if (w_word_valid) w_state_next = (w_word == r_csum) ? START : ERR;
            end
`endif
            START: begin
                busy         = 1'b1;
                core_start   = 1'b1;
                w_state_next = RUN;
            end
            RUN: begin
                core_halt = 1'b0;
                done      = 1'b1;
            end
            ERR:     err = 1'b1;
            default: w_state_next = IDLE;
        endcase
    end

    // Header capture, write-port pipeline, and word and address counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n         <= 32'd0;
            r_word_cnt  <= 32'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_pc_init   <= 32'd0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            r_csum      <= 32'd0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                HDR_CNT: if (w_word_valid) begin
                    r_n <= w_word;
`ifdef MIPS32_LOADER_CHECKSUM_EN
                    r_csum <= w_word;
`endif
                end
                HDR_ADDR: if (w_word_valid && !w_addr_ovf) begin
                    r_mem_addr <= w_word[AW-1:0];
                    r_pc_init  <= w_word;
`ifdef MIPS32_LOADER_CHECKSUM_EN
                    r_csum     <= r_csum ^ w_word;
`endif
                end
                DATA: begin
                    if (w_word_valid) begin
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_word;
                        r_word_cnt  <= r_word_cnt + 32'd1;
`ifdef MIPS32_LOADER_CHECKSUM_EN
                        r_csum      <= r_csum ^ w_word;
`endif
                    end
                    if (r_mem_we) r_mem_addr <= r_mem_addr + AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign core_pc_init = r_pc_init;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Self-checking bench for mips32_prog_loader. Directed and random program
// loads run against a reference model built from the load rules. The model
// gives N writes at A..A+N-1 when N <= MAX_WORDS and A+N <= depth, then a
// single start pulse and the release of the core.
module tb_mips32_prog_loader;

    localparam int AW        = 10;
    localparam int DEPTH     = 1 << AW;
    localparam int MAX_WORDS = 1024;
    localparam int LIMIT     = 200;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_halt;
    logic [31:0]   core_pc_init;
    logic          core_start;
    logic          busy;
    logic          done;
    logic          err;

    mips32_prog_loader #(.AW(AW), .MAX_WORDS(MAX_WORDS)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_halt    (core_halt),
        .core_pc_init (core_pc_init),
        .core_start   (core_start),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Observed write port and start pulses, sampled mid-cycle.
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int n_start, n_b2b, n_start_nohalt, last_we_cyc, start_cyc;
    logic prev_we = 1'b0;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(32'(mem_addr));
            wr_data.push_back(mem_wdata);
            last_we_cyc = cyc;
            if (prev_we) n_b2b++;
        end
        prev_we = mem_we;
        if (core_start) begin
            n_start++;
            start_cyc = cyc;
            if (!core_halt) n_start_nohalt++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] fact [11] = '{
        32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000,
        32'h0e94a000, 32'h14431000, 32'h2c630001, 32'h0e94a000,
        32'h3460fffc, 32'h2542fffe, 32'hfc000000
    };
    logic [31:0] prog [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst      = 1'b1;
        @(posedge clk); #1;
        wr_addr.delete();
        wr_data.delete();
        n_start = 0; n_b2b = 0; n_start_nohalt = 0;
        last_we_cyc = 0; start_cyc = 0;
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int idle_pct);
        int guard;
        while ($urandom_range(99, 0) < idle_pct) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (!in_ready && guard < LIMIT) begin
            @(posedge clk); #1;
            guard++;
        end
        check("byte_accept", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int idle_pct);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], idle_pct);
    endtask

    task automatic wait_end();
        int g;
        g = 0;
        while (!(done || err) && g < LIMIT) begin
            @(posedge clk); #1;
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Full load of prog[0..n-1] with a model-derived expected outcome.
    task automatic run_load(input string tag, input int n, input int a,
                            input int idle_pct, input logic [31:0] flip);
        logic        hdr_ok, addr_ok, exp_load, exp_done;
        logic [31:0] csum, exp_pc;
        int          exp_wr;
        hdr_ok   = (n <= MAX_WORDS);
        addr_ok  = (n == 0) || (longint'(a) + longint'(n) <= longint'(DEPTH));
        exp_load = hdr_ok && addr_ok;
        exp_wr   = exp_load ? n : 0;
        exp_pc   = (exp_load && n != 0) ? 32'(a) : 32'd0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
        exp_done = exp_load && !(n != 0 && flip != 32'd0);
`else
        exp_done = exp_load;
`endif
        reset_dut();
        send_word(32'(n), idle_pct);
        if (hdr_ok && n != 0) send_word(32'(a), idle_pct);
        if (exp_load && n != 0) begin
            csum = 32'(n) ^ 32'(a);
            for (int k = 0; k < n; k++) begin
                send_word(prog[k], idle_pct);
                csum = csum ^ prog[k];
            end
`ifdef MIPS32_LOADER_CHECKSUM_EN
            send_word(csum ^ flip, idle_pct);
`endif
        end
        wait_end();
        check({tag, "_done"},      32'(done),       32'(exp_done));
        check({tag, "_err"},       32'(err),        32'(!exp_done));
        check({tag, "_halt"},      32'(core_halt),  32'(!exp_done));
        check({tag, "_in_ready"},  32'(in_ready),   32'd0);
        check({tag, "_pc_init"},   core_pc_init,    exp_pc);
        check({tag, "_n_start"},   32'(n_start),    32'(exp_done));
        check({tag, "_n_writes"},  32'(wr_addr.size()), 32'(exp_wr));
        check({tag, "_b2b_we"},    32'(n_b2b),      32'd0);
        if (exp_done) begin
            check({tag, "_busy"},  32'(busy),       32'd0);
            check({tag, "_start_halted"}, 32'(n_start_nohalt), 32'd0);
        end
        if (exp_done && n != 0)
            check({tag, "_start_after_write"}, 32'(start_cyc > last_we_cyc), 32'd1);
        for (int k = 0; k < exp_wr && k < wr_addr.size(); k++) begin
            check({tag, "_addr"}, wr_addr[k], 32'(a + k));
            check({tag, "_data"}, wr_data[k], prog[k]);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        n_start = 0; n_b2b = 0; n_start_nohalt = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values while reset is held.
        check("rst_in_ready",  32'(in_ready),   32'd0);
        check("rst_mem_we",    32'(mem_we),     32'd0);
        check("rst_mem_addr",  32'(mem_addr),   32'd0);
        check("rst_mem_wdata", mem_wdata,       32'd0);
        check("rst_pc_init",   core_pc_init,    32'd0);
        check("rst_halt",      32'(core_halt),  32'd1);
        check("rst_start",     32'(core_start), 32'd0);
        check("rst_busy",      32'(busy),       32'd0);
        check("rst_done",      32'(done),       32'd0);
        check("rst_err",       32'(err),        32'd0);

        // Factorial program, continuous stream.
        for (int k = 0; k < 11; k++) prog[k] = fact[k];
        run_load("fact", 11, 0, 0, 32'd0);

        // Single word at address 200.
        prog[0] = 32'h00000007;
        run_load("single", 1, 200, 0, 32'd0);

        // Empty program: release straight after the count.
        run_load("empty", 0, 0, 0, 32'd0);

        // Window overflowing memory by two words.
        for (int k = 0; k < 4; k++) prog[k] = $urandom;
        run_load("ovf", 4, 1022, 0, 32'd0);

        // Window ending exactly at the top of memory.
        run_load("edge", 2, 1022, 0, 32'd0);

        // Word count above the maximum.
        run_load("toobig", MAX_WORDS + 1, 0, 0, 32'd0);

        // Random programs with a sparse stream.
        for (int r = 0; r < 3; r++) begin
            int rn, ra;
            rn = $urandom_range(8, 1);
            ra = $urandom_range(DEPTH - rn, 0);
            for (int k = 0; k < rn; k++) prog[k] = $urandom;
            run_load("rand", rn, ra, 50, 32'd0);
        end

        // Reset in the middle of the factorial load.
        for (int k = 0; k < 11; k++) prog[k] = fact[k];
        reset_dut();
        send_word(32'd11, 0);
        send_word(32'd0, 0);
        for (int k = 0; k < 3; k++) send_word(fact[k], 0);
        send_byte(prog[3][31:24], 0);
        send_byte(prog[3][23:16], 0);
        check("mid_writes", 32'(wr_addr.size()), 32'd3);
        check("mid_busy",   32'(busy),           32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready",  32'(in_ready),   32'd0);
        check("mid_rst_mem_we",    32'(mem_we),     32'd0);
        check("mid_rst_mem_addr",  32'(mem_addr),   32'd0);
        check("mid_rst_mem_wdata", mem_wdata,       32'd0);
        check("mid_rst_halt",      32'(core_halt),  32'd1);
        check("mid_rst_start",     32'(core_start), 32'd0);
        check("mid_rst_busy",      32'(busy),       32'd0);
        check("mid_rst_done",      32'(done),       32'd0);
        check("mid_rst_err",       32'(err),        32'd0);
        repeat (2) @(posedge clk);
        #1;

        // The factorial program again, with in_valid at 30% duty.
        run_load("fact_sparse", 11, 0, 70, 32'd0);

`ifdef MIPS32_LOADER_CHECKSUM_EN
        // A corrupted checksum must abort without releasing the core.
        run_load("csum_bad", 11, 0, 0, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips32_prog_loader.md
Name: mips32_prog_loader

Overview:
- Boot-time loader in front of the MIPS32 pipeline. It replaces bench-side poking of instruction/data memory and PC/HALTED.
- Consumes a byte stream carrying a header (word count, load address) and the program words. Writes each word into core memory.
- Then releases the core: PC initialised to the load address, one start pulse, halt deasserted.
- Sits between the host/UART byte source and the pipe_MIPS32 memory write port and control inputs.

Parameters:
- AW, 10, memory word-address width; memory depth = 2**AW words.
- MAX_WORDS, 1024, largest accepted program word count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte, big-endian within each 32-bit word.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  word address for the write.
- mem_wdata  out  32  write data.
- core_halt  out  1  holds the core halted (drives HALTED).
- core_pc_init  out  32  PC value to load (word index).
- core_start  out  1  one-cycle pulse; the core loads PC and clears TAKEN_BRANCH.
- busy  out  1  a load is in progress.
- done  out  1  core released; sticky until reset.
- err  out  1  load aborted; sticky until reset.

Behaviour:
- Reset values (async assert, released synchronously):
  - state=IDLE; in_ready=0; mem_we=0; mem_addr=0; mem_wdata=0; core_pc_init=0.
  - core_halt=1; core_start=0; busy=0; done=0; err=0.
  - Byte counter and word counter = 0.
- Byte handshake: a byte transfers when in_valid && in_ready. in_ready=1 only in HDR_CNT, HDR_ADDR, DATA and CHK. No transfer in any other state.
- Word assembly: a 2-bit byte index; the first byte goes to bits [31:24]. The word completes on the 4th transfer; the index wraps to 0.
- States:
  - IDLE: busy=0. Moves to HDR_CNT on the cycle after reset release.
  - HDR_CNT: busy=1. The completed word is N.
    - N==0 -> START (no writes).
    - N>MAX_WORDS -> ERR.
    - Otherwise -> HDR_ADDR.
  - HDR_ADDR: the completed word is A.
    - A+N > 2**AW (33-bit compare) -> ERR.
    - Otherwise latch mem_addr=A[AW-1:0] and core_pc_init=A, then -> DATA.
  - DATA: each completed word produces mem_we=1 for exactly one cycle, on the cycle after the 4th byte is accepted, with mem_wdata=that word and mem_addr=A+k.
    - mem_addr increments after each write.
    - After the Nth write -> START, or -> CHK when CHECKSUM_EN is defined.
  - START: core_start=1 for one cycle; core_halt still 1. -> RUN.
  - RUN: core_halt=0, done=1, busy=0, in_ready=0. Terminal until reset.
  - ERR: err=1, core_halt=1, in_ready=0, no further writes. Terminal until reset.
- Partial bytes of a word never produce a write. An idle stream mid-word simply stalls; there is no timeout.
- The pipelined write overlaps acceptance of the next word's first byte. mem_we never occurs in back-to-back cycles, because a word takes at least 4 cycles.
- Reset mid-load: outputs return to reset values immediately. Already-written words remain in memory. The core stays halted.

Optional Feature:
- Macro: MIPS32_LOADER_CHECKSUM_EN.
- Defined: after the N data words, one extra word C is received in CHK. C must equal the XOR of N, A and all data words.
  - Match -> START.
  - Mismatch -> ERR; core never released.
- Undefined: CHK state and checksum logic absent; DATA -> START directly.

Decomposition:
- Package mips32_loader_pkg holds:
  - state enum (IDLE, HDR_CNT, HDR_ADDR, DATA, CHK, START, RUN, ERR);
  - WORD_W=32;
  - HALT opcode constant 6'h3f, shared with the core.
- One sub-module: mips32_byte_packer (byte index, shift register, word_valid pulse). It is reused by the future trace/dump unit.

Test Plan:
- Factorial program: header N=11, A=0, words 280a00c8, 28020001, 0e94a000, 21430000, 0e94a000, 14431000, 2c630001, 0e94a000, 3460fffc, 2542fffe, fc000000.
  -> 11 mem_we pulses at addr 0..10 with exactly those words; core_pc_init=0; one core_start pulse; core_halt falls; done=1.
- N=1, A=200, word 00000007 -> single write Mem[200]=7; pc_init=200; done=1.
- N=0, A omitted -> no writes; START and RUN reached after the 4 count bytes.
- N=4, A=1022 (overflow) -> err=1; no mem_we; core_halt stays 1; in_ready=0.
- in_valid toggled randomly 30% duty across the factorial program -> identical write sequence. Assert rst after 3 data words -> all outputs at reset values the same cycle; core_halt=1.
- With MIPS32_LOADER_CHECKSUM_EN: correct XOR -> done=1. Checksum with bit0 flipped -> err=1, no core_start.
